// File: rtl/ex_stage_pipe.sv
// Registered execute stage: valid/ready handshake, ALU, iterative shift-add multiplier, flush.
// Results, condition codes, opcode and destination register all leave from one output register.
module ex_stage_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DR_W  = 3,
  parameter int unsigned OP_W  = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [WIDTH-1:0]  OPERAND1,
  input  logic [WIDTH-1:0]  OPERAND2,
  input  logic [WIDTH-1:0]  PC,
  input  logic [WIDTH-1:0]  PC_OFFSET,
  input  logic [WIDTH-1:0]  MEM_OFFSET,
  input  logic [DR_W-1:0]   DR,
  input  logic [OP_W-1:0]   ALUOP,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [WIDTH-1:0]  RESULT,
  output logic [2:0]        CC,
  output logic [OP_W-1:0]   OP_EX_RETURN,
  output logic [DR_W-1:0]   DR_EX_RETURN
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [OP_W-1:0] OpBr  = OP_W'(0);
  localparam logic [OP_W-1:0] OpAdd = OP_W'(1);
  localparam logic [OP_W-1:0] OpMem = OP_W'(2);
  localparam logic [OP_W-1:0] OpAnd = OP_W'(3);
  localparam logic [OP_W-1:0] OpXor = OP_W'(4);
  localparam logic [OP_W-1:0] OpShf = OP_W'(5);
  localparam logic [OP_W-1:0] OpMul = OP_W'(6);

  typedef enum logic [0:0] {StIdle, StMulBusy} state_e;

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [2:0]        cc_q, cc_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DR_W-1:0]   dr_q, dr_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DR_W-1:0]   mul_dr_q, mul_dr_d;

  logic [WIDTH-1:0]  pc_off_sh, mem_off_sh, alu_res, mul_sum;
  logic [3:0]        shamt;
  logic              accept, drain;

  function automatic logic [2:0] nzp(input logic [WIDTH-1:0] v);
    if (v == '0)          return 3'b010;
    else if (v[WIDTH-1])  return 3'b100;
    else                  return 3'b001;
  endfunction

  // Offsets are in word units; the shift drops the MSB.
  assign pc_off_sh  = PC_OFFSET << 1;
  assign mem_off_sh = MEM_OFFSET << 1;
  assign shamt      = OPERAND2[3:0];

  always_comb begin
    alu_res = '0;
    case (ALUOP)
      OpBr:  alu_res = PC + pc_off_sh + WIDTH'(2);
      OpAdd: alu_res = OPERAND1 + OPERAND2;
      OpMem: alu_res = OPERAND1 + mem_off_sh;
      OpAnd: alu_res = OPERAND1 & OPERAND2;
      OpXor: alu_res = OPERAND1 ^ OPERAND2;
      OpShf: begin
        case (OPERAND2[5:4])
          2'b00:   alu_res = OPERAND1 << shamt;
          2'b01:   alu_res = OPERAND1 >> shamt;
          2'b11:   alu_res = $unsigned($signed(OPERAND1) >>> shamt);
          default: alu_res = OPERAND1;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  assign mul_sum  = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign drain    = out_valid_q && OUT_READY;
  assign IN_READY = (state_q == StIdle) && (!out_valid_q || OUT_READY) && !FLUSH;
  assign accept   = IN_VALID && IN_READY;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    cc_d        = cc_q;
    op_d        = op_q;
    dr_d        = dr_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mul_dr_d    = mul_dr_q;
    // Flush wins over both accept and multiplier completion.
    if (FLUSH) begin
      out_valid_d = 1'b0;
      state_d     = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (drain) out_valid_d = 1'b0;
          if (accept) begin
            if (ALUOP == OpMul) begin
              mcand_d  = OPERAND1;
              mplier_d = OPERAND2;
              acc_d    = '0;
              cnt_d    = CntW'(WIDTH);
              mul_dr_d = DR;
              state_d  = StMulBusy;
            end else begin
              out_valid_d = 1'b1;
              result_d    = alu_res;
              cc_d        = nzp(alu_res);
              op_d        = ALUOP;
              dr_d        = DR;
            end
          end
        end
        StMulBusy: begin
          if (drain) out_valid_d = 1'b0;
          acc_d    = mul_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d     = StIdle;
            out_valid_d = 1'b1;
            result_d    = mul_sum;
            cc_d        = nzp(mul_sum);
            op_d        = OpMul;
            dr_d        = mul_dr_q;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cc_q        <= 3'b000;
      op_q        <= '0;
      dr_q        <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      mul_dr_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      cc_q        <= cc_d;
      op_q        <= op_d;
      dr_q        <= dr_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mul_dr_q    <= mul_dr_d;
    end
  end

  assign OUT_VALID    = out_valid_q;
  assign RESULT       = result_q;
  assign CC           = cc_q;
  assign OP_EX_RETURN = op_q;
  assign DR_EX_RETURN = dr_q;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Bench for ex_stage_pipe: directed scenarios followed by random traffic against a
// transaction-level reference (direct arithmetic, fixed multiply latency).
module tb_ex_stage_pipe;

  localparam int unsigned W = 16;

  logic        CLK = 1'b0;
  logic        RESET, FLUSH, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [15:0] OPERAND1, OPERAND2, PC, PC_OFFSET, MEM_OFFSET, RESULT;
  logic [2:0]  DR, ALUOP, CC, OP_EX_RETURN, DR_EX_RETURN;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference state: visible output slot plus an outstanding multiply.
  logic        m_valid = 1'b0;
  logic [15:0] m_res = '0;
  logic [2:0]  m_cc = '0, m_op = '0, m_dr = '0;
  bit          m_busy = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_pend = '0;
  logic [2:0]  m_pdr = '0;

  always #5 CLK = ~CLK;

  ex_stage_pipe #(.WIDTH(16), .DR_W(3), .OP_W(3)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OPERAND1(OPERAND1), .OPERAND2(OPERAND2), .PC(PC), .PC_OFFSET(PC_OFFSET),
    .MEM_OFFSET(MEM_OFFSET), .DR(DR), .ALUOP(ALUOP), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .RESULT(RESULT), .CC(CC), .OP_EX_RETURN(OP_EX_RETURN),
    .DR_EX_RETURN(DR_EX_RETURN)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] pc,
                                          input logic [15:0] pco, input logic [15:0] mo);
    logic [31:0] t;
    int          s;
    int          sh;
    sh = int'(b[3:0]);
    case (op)
      3'd0: t = 32'(pc) + 32'(pco) * 2 + 2;
      3'd1: t = 32'(a) + 32'(b);
      3'd2: t = 32'(a) + 32'(mo) * 2;
      3'd3: t = 32'(a & b);
      3'd4: t = 32'(a ^ b);
      3'd5: begin
        case (b[5:4])
          2'b00: t = 32'(a) << sh;
          2'b01: t = 32'(a) >> sh;
          2'b11: begin
            s = int'($signed(a));
            t = 32'(s >>> sh);
          end
          default: t = 32'(a);
        endcase
      end
      3'd6: t = 32'(a) * 32'(b);
      default: t = '0;
    endcase
    return t[15:0];
  endfunction

  function automatic logic [2:0] ref_cc(input logic [15:0] r);
    if (r == 16'd0) return 3'b010;
    if (r > 16'h7FFF) return 3'b100;
    return 3'b001;
  endfunction

  task automatic model_load(input logic [15:0] r, input logic [2:0] op, input logic [2:0] dr);
    m_valid = 1'b1;
    m_res   = r;
    m_cc    = ref_cc(r);
    m_op    = op;
    m_dr    = dr;
  endtask

  // Called at a negedge: drive one cycle of inputs, advance the reference, compare at next negedge.
  task automatic step(input bit iv, input logic [2:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] pc, input logic [15:0] pco,
                      input logic [15:0] mo, input logic [2:0] dr, input bit ordy, input bit fl);
    bit          rdy;
    logic [15:0] r;
    IN_VALID = iv; ALUOP = op; OPERAND1 = a; OPERAND2 = b; PC = pc; PC_OFFSET = pco;
    MEM_OFFSET = mo; DR = dr; OUT_READY = ordy; FLUSH = fl;
    #1;
    rdy = !m_busy && (!m_valid || ordy) && !fl;
    check("in_ready", {31'd0, IN_READY}, {31'd0, rdy});
    if (fl) begin
      m_valid = 1'b0;
      m_busy  = 1'b0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 1'b0;
        model_load(m_pend, 3'd6, m_pdr);
      end
    end else begin
      if (m_valid && ordy) m_valid = 1'b0;
      if (iv && rdy) begin
        r = ref_alu(op, a, b, pc, pco, mo);
        if (op == 3'd6) begin
          m_busy = 1'b1;
          m_cnt  = W;
          m_pend = r;
          m_pdr  = dr;
        end else begin
          model_load(r, op, dr);
        end
      end
    end
    @(negedge CLK);
    check("out_valid", {31'd0, OUT_VALID}, {31'd0, m_valid});
    if (m_valid) begin
      check("result", {16'd0, RESULT}, {16'd0, m_res});
      check("cc", {29'd0, CC}, {29'd0, m_cc});
      check("op", {29'd0, OP_EX_RETURN}, {29'd0, m_op});
      check("dr", {29'd0, DR_EX_RETURN}, {29'd0, m_dr});
    end
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 3'd0, '0, '0, '0, '0, '0, 3'd0, ordy, 1'b0);
  endtask

  // Cycles from the accept edge until OUT_VALID is seen, bounded.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!OUT_VALID && lat < 40) begin
      idle(1'b1);
      lat++;
    end
  endtask

  int lat;

  initial begin
    RESET = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    OPERAND1 = '0; OPERAND2 = '0; PC = '0; PC_OFFSET = '0; MEM_OFFSET = '0; DR = '0; ALUOP = '0;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst_result", {16'd0, RESULT}, 32'd0);
    check("rst_cc", {29'd0, CC}, 32'd0);
    check("rst_op", {29'd0, OP_EX_RETURN}, 32'd0);
    check("rst_dr", {29'd0, DR_EX_RETURN}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    // ADD with overflow into the sign bit, then stall
    step(1'b1, 3'd1, 16'h7FFF, 16'h0001, '0, '0, '0, 3'd2, 1'b1, 1'b0);
    check("add_res", {16'd0, RESULT}, 32'h8000);
    check("add_cc", {29'd0, CC}, 32'b100);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd1, 16'hFFFF, 16'h0001, '0, '0, '0, 3'd3, 1'b0, 1'b0);
      check("stall_res", {16'd0, RESULT}, 32'h8000);
      check("stall_ready", {31'd0, IN_READY}, 32'd0);
    end
    step(1'b1, 3'd1, 16'hFFFF, 16'h0001, '0, '0, '0, 3'd3, 1'b1, 1'b0);
    check("add_zero", {16'd0, RESULT}, 32'h0000);
    check("add_zero_cc", {29'd0, CC}, 32'b010);

    step(1'b1, 3'd0, '0, '0, 16'h3000, 16'hFFFE, '0, 3'd1, 1'b1, 1'b0);
    check("br_res", {16'd0, RESULT}, 32'h2FFE);
    step(1'b1, 3'd2, 16'h4000, '0, '0, '0, 16'h0003, 3'd4, 1'b1, 1'b0);
    check("mem_res", {16'd0, RESULT}, 32'h4006);
    check("mem_cc", {29'd0, CC}, 32'b001);

    step(1'b1, 3'd5, 16'h8004, 16'h0032, '0, '0, '0, 3'd1, 1'b1, 1'b0);
    check("rshfa", {16'd0, RESULT}, 32'hE001);
    step(1'b1, 3'd5, 16'h8004, 16'h0012, '0, '0, '0, 3'd1, 1'b1, 1'b0);
    check("rshfl", {16'd0, RESULT}, 32'h2001);
    step(1'b1, 3'd5, 16'h8004, 16'h0002, '0, '0, '0, 3'd1, 1'b1, 1'b0);
    check("lshf", {16'd0, RESULT}, 32'h0010);

    // Multiplies: latency and wrap-around
    step(1'b1, 3'd6, 16'h0123, 16'h0010, '0, '0, '0, 3'd5, 1'b1, 1'b0);
    wait_valid(lat);
    check("mul_lat", 32'(lat), 32'd17);
    check("mul_res", {16'd0, RESULT}, 32'h1230);
    step(1'b1, 3'd6, 16'hFFFF, 16'hFFFF, '0, '0, '0, 3'd6, 1'b1, 1'b0);
    wait_valid(lat);
    check("mul2_lat", 32'(lat), 32'd17);
    check("mul2_res", {16'd0, RESULT}, 32'h0001);

    // Flush five cycles into a multiply, then an ADD right behind it
    step(1'b1, 3'd6, 16'h1111, 16'h0003, '0, '0, '0, 3'd7, 1'b1, 1'b0);
    repeat (4) idle(1'b1);
    step(1'b1, 3'd1, 16'h0001, 16'h0001, '0, '0, '0, 3'd2, 1'b1, 1'b1);
    check("flush_mul_valid", {31'd0, OUT_VALID}, 32'd0);
    step(1'b1, 3'd1, 16'h1234, 16'h1111, '0, '0, '0, 3'd2, 1'b1, 1'b0);
    check("post_flush_valid", {31'd0, OUT_VALID}, 32'd1);
    check("post_flush_res", {16'd0, RESULT}, 32'h2345);
    repeat (20) idle(1'b1);

    // Flush of a stalled result
    step(1'b1, 3'd4, 16'h00FF, 16'h0F0F, '0, '0, '0, 3'd3, 1'b1, 1'b0);
    step(1'b0, 3'd0, '0, '0, '0, '0, '0, 3'd0, 1'b0, 1'b1);
    check("flush_stall_valid", {31'd0, OUT_VALID}, 32'd0);

    // Reset in the middle of a multiply
    step(1'b1, 3'd1, 16'h0005, 16'h0005, '0, '0, '0, 3'd1, 1'b1, 1'b0);
    step(1'b1, 3'd6, 16'h0007, 16'h0009, '0, '0, '0, 3'd1, 1'b1, 1'b0);
    repeat (3) idle(1'b1);
    RESET = 1'b1;
    #1;
    check("rst_mul_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst_mul_res", {16'd0, RESULT}, 32'd0);
    check("rst_mul_cc", {29'd0, CC}, 32'd0);
    m_valid = 1'b0; m_busy = 1'b0; m_cnt = 0;
    @(negedge CLK);
    RESET = 1'b0; IN_VALID = 1'b0; FLUSH = 1'b0;
    #1;
    check("rst_mul_ready", {31'd0, IN_READY}, 32'd1);
    repeat (20) idle(1'b1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step(bit'($urandom_range(0, 9) < 7), 3'($urandom), 16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom),
           bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 31) == 0));
    end
    repeat (20) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
Parametrised, registered execute stage for the 5-stage pipeline. It replaces the purely combinational execute logic with the following:
- a valid/ready handshake towards decode and memory stages;
- a wider ALU opcode space;
- an iterative multi-cycle multiplier;
- a flush input for branch recovery.

The block sits between ID and MEM. It produces the ALU result, the branch target or memory address, NZP condition codes, and the forwarded opcode and destination register, all from an output register.

Parameters:
WIDTH, 16, datapath width of operands, PC, offsets and RESULT
DR_W, 3, destination-register index width
OP_W, 3, ALU opcode width (fixed encoding below; must be >= 3)

Ports:
CLK  input  1  clock, all state on rising edge
RESET  input  1  asynchronous, active-high reset
FLUSH  input  1  synchronous kill: drops output register contents and aborts an in-progress MUL
IN_VALID  input  1  ID presents a valid instruction
IN_READY  output  1  stage can accept an instruction this cycle
OPERAND1  input  WIDTH  source operand 1
OPERAND2  input  WIDTH  source operand 2
PC  input  WIDTH  PC of the instruction
PC_OFFSET  input  WIDTH  sign-extended branch offset (word units)
MEM_OFFSET  input  WIDTH  sign-extended memory offset (word units)
DR  input  DR_W  destination register
ALUOP  input  OP_W  operation select
OUT_VALID  output  1  RESULT/CC/OP/DR valid for MEM
OUT_READY  input  1  MEM accepts output this cycle
RESULT  output  WIDTH  registered ALU result
CC  output  3  registered NZP of RESULT: {N,Z,P}
OP_EX_RETURN  output  OP_W  registered ALUOP
DR_EX_RETURN  output  DR_W  registered DR

Behaviour:
- Reset is asynchronous and active-high:
  - OUT_VALID=0, RESULT=0, CC=3'b000, OP_EX_RETURN=0, DR_EX_RETURN=0;
  - FSM goes to IDLE and the MUL counter clears.
  - Reset asserted mid-MUL aborts the MUL with no output.
- Opcodes; all arithmetic is modulo 2^WIDTH, and offsets are shifted left by 1 with the shifted-out MSB discarded:
  - 000 BR: PC + (PC_OFFSET<<1) + 2
  - 001 ADD: OPERAND1 + OPERAND2
  - 010 MEM (LDW/STW): OPERAND1 + (MEM_OFFSET<<1)
  - 011 AND: OPERAND1 & OPERAND2
  - 100 XOR: OPERAND1 ^ OPERAND2
  - 101 SHF: OPERAND2[5:4] selects the shift type; amount is OPERAND2[3:0] (for WIDTH>16, bits [3:0] only):
    - 00 = LSHF of OPERAND1
    - 01 = RSHFL (logical right)
    - 11 = RSHFA (arithmetic right)
    - 10 = result OPERAND1 unchanged
  - 110 MUL: low WIDTH bits of OPERAND1*OPERAND2, unsigned
  - 111 reserved: RESULT=0
- CC (priority order):
  - 3'b010 if RESULT==0;
  - otherwise 3'b100 if RESULT[WIDTH-1]==1;
  - otherwise 3'b001.
  - CC is computed for every opcode, including BR and MEM, and is registered together with RESULT.
- Handshake:
  - Transfer in occurs when IN_VALID && IN_READY.
  - IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY) && !FLUSH.
  - Transfer out occurs when OUT_VALID && OUT_READY.
  - While OUT_VALID && !OUT_READY, all outputs hold stable.
- FSM states: IDLE and MUL_BUSY.
  - IDLE, accept of a non-MUL op: output register loads on the same edge, so OUT_VALID=1 on the next cycle (latency 1). Back-to-back accepts give one result per cycle.
  - IDLE, accept of MUL: latch the operands and DR, clear the accumulator, set the counter to WIDTH, and go to MUL_BUSY. If the output register was being drained that edge, OUT_VALID goes to 0.
  - MUL_BUSY, each cycle:
    - if multiplier bit0 is set, accumulator += multiplicand;
    - multiplicand <<= 1, multiplier >>= 1, counter decrements.
  - MUL_BUSY, on the edge where the counter reaches 0: load the output register (OUT_VALID=1) and return to IDLE.
  - MUL latency is WIDTH+1 cycles from the accept edge to OUT_VALID. IN_READY=0 throughout MUL_BUSY.
  - The MUL cannot complete while a prior result is still stalled, because accept required the output slot to be free or draining.
- FLUSH=1 at an edge:
  - OUT_VALID goes to 0;
  - MUL_BUSY returns to IDLE with the result discarded;
  - IN_VALID that cycle is not accepted (IN_READY=0).
  - FLUSH takes priority over MUL completion and over accept.
  - Data registers may retain stale values.
- Simultaneous drain and accept in the same cycle: the new result replaces the old one, with OUT_VALID remaining 1 and no bubble.

Test Plan:
- Reset mid-MUL: assert RESET during MUL_BUSY -> OUT_VALID=0, RESULT=0, CC=000 immediately; IN_READY=1 after release.
- ADD and stall: ADD 0x7FFF+0x0001, OUT_READY=0 for 3 cycles -> RESULT=0x8000, CC=100 held stable for 3 cycles, IN_READY=0; then ADD 0xFFFF+0x0001 -> RESULT=0x0000, CC=010.
- BR and MEM: BR with PC=0x3000, PC_OFFSET=0xFFFE -> RESULT=0x2FFE. MEM with OPERAND1=0x4000, MEM_OFFSET=0x0003 -> 0x4006, CC=001.
- SHF: OPERAND1=0x8004, OPERAND2=0x0032 -> 0xE001; OPERAND2=0x0012 -> 0x2001; OPERAND2=0x0002 -> 0x0010.
- MUL: 0x0123*0x0010 -> RESULT=0x1230 with OUT_VALID exactly 17 cycles after accept, IN_READY=0 in between. 0xFFFF*0xFFFF -> 0x0001.
- FLUSH during MUL_BUSY at cycle 5 -> no OUT_VALID; an ADD issued the next cycle completes with latency 1. FLUSH with OUT_VALID=1 and OUT_READY=0 -> OUT_VALID=0 next cycle.
